// File: rtl/ldpc_pkg.sv
// Shared LDPC defaults, sign-magnitude message type and check-node FSM states.
// Declarations only: no latency, no backpressure.
package ldpc_pkg;

   localparam int DATA_WIDTH_DEF = 6;
   localparam int DEGREE_DEF     = 6;

   typedef struct packed {
      logic                      sign;
      logic [DATA_WIDTH_DEF-1:0] mag;
   } msg_t;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_EMIT  = 1'b1
   } cnu_state_t;

endpackage

// File: rtl/cnu_serial_minsum_if.sv
// Message-in / message-out valid-ready bundle of the serial check-node unit.
// Wires only: no latency; each direction carries its own ready for backpressure.
interface cnu_serial_minsum_if #(
   parameter int DATA_WIDTH = ldpc_pkg::DATA_WIDTH_DEF,
   parameter int DEGREE     = ldpc_pkg::DEGREE_DEF,
   parameter int IDX_W      = $clog2(DEGREE)
);

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH:0]   in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH:0]   out_data;
   logic [IDX_W-1:0]      out_idx;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx
   );

endinterface

// File: rtl/cnu_min_update.sv
// Running two-minimum tracker step: folds one magnitude into (min1, idx1, min2).
// Purely combinational, zero latency, no backpressure.
module cnu_min_update
   import ldpc_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int IDX_W      = $clog2(DEGREE_DEF)
) (
   input  logic [DATA_WIDTH-1:0] i_m,
   input  logic [IDX_W-1:0]      i_cnt,
   input  logic [DATA_WIDTH-1:0] i_min1,
   input  logic [DATA_WIDTH-1:0] i_min2,
   input  logic [IDX_W-1:0]      i_idx1,
   output logic [DATA_WIDTH-1:0] o_min1,
   output logic [DATA_WIDTH-1:0] o_min2,
   output logic [IDX_W-1:0]      o_idx1
);

   // Strict compares: an equal later magnitude never steals idx1.
   always_comb begin
      o_min1 = i_min1;
      o_min2 = i_min2;
      o_idx1 = i_idx1;
      if (i_m < i_min1) begin
         o_min2 = i_min1;
         o_min1 = i_m;
         o_idx1 = i_cnt;
      end else if (i_m < i_min2) begin
         o_min2 = i_m;
      end
   end

endmodule

// File: rtl/cnu_serial_minsum.sv
// Serial min-sum check node: absorbs DEGREE messages, then emits DEGREE extrinsic ones.
// Latency DEGREE+1 cycles to first output; in_ready low while emitting, output held on out_ready=0.
module cnu_serial_minsum
   import ldpc_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEGREE     = DEGREE_DEF,
   parameter int IDX_W      = $clog2(DEGREE)
) (
   input logic                clk,
   input logic                rst_n,
   cnu_serial_minsum_if.slave bus
);

   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEGREE - 1);
   localparam logic [DATA_WIDTH-1:0] MAG_ONES = '1;

   cnu_state_t            r_state;
   cnu_state_t            w_state_nxt;
   logic                  r_in_ready;
   logic                  w_out_valid;
   logic                  w_in_fire;
   logic                  w_out_fire;
   logic                  w_last;
   logic                  w_in_sign;
   logic [DATA_WIDTH-1:0] w_in_mag;
   logic [IDX_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_idx1;
   logic [IDX_W-1:0]      w_idx1_nxt;
   logic [DATA_WIDTH-1:0] r_min1;
   logic [DATA_WIDTH-1:0] r_min2;
   logic [DATA_WIDTH-1:0] w_min1_nxt;
   logic [DATA_WIDTH-1:0] w_min2_nxt;
   logic                  r_sign_prod;
   logic [DEGREE-1:0]     r_sign_buf;

   assign w_in_sign  = bus.in_data[DATA_WIDTH];
   assign w_in_mag   = bus.in_data[DATA_WIDTH-1:0];
   assign w_last     = (r_cnt == LAST_IDX);
   assign w_in_fire  = bus.in_valid & r_in_ready;
   assign w_out_fire = w_out_valid & bus.out_ready;

   cnu_min_update #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_min_update (
      .i_m    (w_in_mag),
      .i_cnt  (r_cnt),
      .i_min1 (r_min1),
      .i_min2 (r_min2),
      .i_idx1 (r_idx1),
      .o_min1 (w_min1_nxt),
      .o_min2 (w_min2_nxt),
      .o_idx1 (w_idx1_nxt)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_out_valid = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            if (w_in_fire && w_last) begin
               w_state_nxt = ST_EMIT;
            end
         end
         ST_EMIT: begin
            w_out_valid = 1'b1;
            if (w_out_fire && w_last) begin
               w_state_nxt = ST_ACCUM;
            end
         end
      endcase
   end

   // in_ready is registered so it stays low through reset and rises on the first edge after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_ACCUM;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt == ST_ACCUM);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_sign_prod <= 1'b0;
         r_sign_buf  <= '0;
         r_idx1      <= '0;
         r_min1      <= MAG_ONES;
         r_min2      <= MAG_ONES;
      end else if (w_in_fire) begin
         r_sign_buf[r_cnt] <= w_in_sign;
         r_sign_prod       <= r_sign_prod ^ w_in_sign;
         r_min1            <= w_min1_nxt;
         r_min2            <= w_min2_nxt;
         r_idx1            <= w_idx1_nxt;
         r_cnt             <= w_last ? '0 : r_cnt + IDX_W'(1);
      end else if (w_out_fire) begin
         if (w_last) begin
            r_cnt       <= '0;
            r_sign_prod <= 1'b0;
            r_idx1      <= '0;
            r_min1      <= MAG_ONES;
            r_min2      <= MAG_ONES;
         end else begin
            r_cnt <= r_cnt + IDX_W'(1);
         end
      end
   end

   // Each edge's extrinsic value excludes itself: sign via XOR-out, magnitude via min2 at idx1.
   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_idx   = r_cnt;
   assign bus.out_data  = {r_sign_prod ^ r_sign_buf[r_cnt], (r_cnt == r_idx1) ? r_min2 : r_min1};

endmodule

// File: tb/tb_cnu_serial_minsum.sv
// Self-checking bench for cnu_serial_minsum: directed vectors, reset aborts, randomized nodes.
// Reference model computes each extrinsic message directly as sign/min over the other edges.
module tb_cnu_serial_minsum;
   import ldpc_pkg::*;

   localparam int DEG = 6;
   localparam int MW  = 7;
   localparam int NB  = DEG * MW;

   typedef logic [NB-1:0] node_t;

   typedef struct {
      string name;
      node_t ins;
      node_t exps;
      int    stall;
      int    cycles;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests   = 0;
   int   n_fail    = 0;
   int   total_out = 0;
   int   nodes_run = 0;

   always #5 clk = ~clk;

   cnu_serial_minsum_if bus ();

   cnu_serial_minsum dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [MW-1:0] msg_at(input node_t n, input int k);
      return n[(DEG-1-k)*MW +: MW];
   endfunction

   // Extrinsic rule: sign = XOR of the other signs, magnitude = min of the other magnitudes.
   function automatic node_t model(input node_t ins);
      node_t r;
      msg_t  a;
      logic  s;
      logic [5:0] mn;
      r = '0;
      for (int j = 0; j < DEG; j++) begin
         s  = 1'b0;
         mn = 6'h3f;
         for (int k = 0; k < DEG; k++) begin
            if (k != j) begin
               a = msg_at(ins, k);
               s = s ^ a.sign;
               if (a.mag < mn) mn = a.mag;
            end
         end
         r[(DEG-1-j)*MW +: MW] = {s, mn};
      end
      return r;
   endfunction

   task automatic run_node(input string nm, input node_t ins, input node_t exps, input int vld_pct,
                           input int rdy_pct, input int stall_idx, output int cycles);
      int ni, no, stalls, iter;
      bit started;
      ni = 0; no = 0; stalls = 0; iter = 0; started = 0; cycles = 0;
      while (no < DEG && iter < 500) begin
         @(negedge clk);
         iter++;
         bus.in_valid  = (ni < DEG) && ($urandom_range(99) < vld_pct);
         bus.in_data   = (ni < DEG) ? msg_at(ins, ni) : '0;
         bus.out_ready = ($urandom_range(99) < rdy_pct);
         if (bus.out_valid && no == stall_idx && stalls < 3) begin
            bus.out_ready = 1'b0;
            stalls++;
            check({nm, " stall out_idx"}, 32'(bus.out_idx), no);
            check({nm, " stall out_data"}, 32'(bus.out_data), 32'(msg_at(exps, no)));
            check({nm, " stall in_ready"}, 32'(bus.in_ready), 0);
         end
         if (bus.in_valid && bus.in_ready) begin
            ni++;
            started = 1;
         end
         if (started) cycles++;
         if (bus.out_valid && bus.out_ready) begin
            check({nm, " out_idx"}, 32'(bus.out_idx), no);
            check({nm, " out_data"}, 32'(bus.out_data), 32'(msg_at(exps, no)));
            check({nm, " in_ready during emit"}, 32'(bus.in_ready), 0);
            no++;
            total_out++;
         end
      end
      check({nm, " inputs taken"}, ni, DEG);
      check({nm, " outputs given"}, no, DEG);
      nodes_run++;
   endtask

   task automatic release_and_check_quiet(input string nm);
      bit stale;
      stale = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (bus.out_valid) stale = 1;
      end
      check({nm, " no stale out_valid"}, 32'(stale), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  tbl [6];
      node_t r;
      int    cyc, vp, rp;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;

      repeat (3) @(negedge clk);
      check("reset in_ready", 32'(bus.in_ready), 0);
      check("reset out_valid", 32'(bus.out_valid), 0);
      check("reset out_idx", 32'(bus.out_idx), 0);
      rst_n = 1'b1;
      #1;
      check("in_ready before first edge", 32'(bus.in_ready), 0);
      @(negedge clk);
      check("in_ready after first edge", 32'(bus.in_ready), 1);

      tbl[0] = '{name: "mixed", cycles: 12, stall: -1,
                 ins:  {7'b0000101, 7'b1000010, 7'b0000111, 7'b0000100, 7'b1001001, 7'b0001100},
                 exps: {7'b0000010, 7'b1000100, 7'b0000010, 7'b0000010, 7'b1000010, 7'b0000010}};
      tbl[1] = '{name: "ties", cycles: 12, stall: -1,
                 ins:  {7'd3, 7'd3, 7'd8, 7'd8, 7'd8, 7'd8},
                 exps: {6{7'd3}}};
      tbl[2] = '{name: "neg32", cycles: 12, stall: -1,
                 ins:  {7'b1100000, {5{7'b0111111}}},
                 exps: {7'b0111111, {5{7'b1100000}}}};
      tbl[3] = '{name: "allneg", cycles: 12, stall: -1,
                 ins:  {7'b1000111, 7'b1000110, 7'b1000101, 7'b1000100, 7'b1000011, 7'b1000010},
                 exps: {{5{7'b1000010}}, 7'b1000011}};
      tbl[4] = '{name: "allmax", cycles: 12, stall: -1,
                 ins:  {6{7'b0111111}},
                 exps: {6{7'b0111111}}};
      tbl[5] = '{name: "stall2", cycles: 15, stall: 2,
                 ins:  {7'b0000101, 7'b1000010, 7'b0000111, 7'b0000100, 7'b1001001, 7'b0001100},
                 exps: {7'b0000010, 7'b1000100, 7'b0000010, 7'b0000010, 7'b1000010, 7'b0000010}};

      for (int i = 0; i < 6; i++) begin
         run_node(tbl[i].name, tbl[i].ins, tbl[i].exps, 100, 100, tbl[i].stall, cyc);
         check({tbl[i].name, " cycles per node"}, cyc, tbl[i].cycles);
         @(negedge clk);
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b0;
         check({tbl[i].name, " in_ready back"}, 32'(bus.in_ready), 1);
         check({tbl[i].name, " out_valid idle"}, 32'(bus.out_valid), 0);
      end

      // Abort a node mid-accumulation; small magnitudes would poison the next node if kept.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = 7'b1000001;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      #1;
      check("accum abort in_ready", 32'(bus.in_ready), 0);
      check("accum abort out_valid", 32'(bus.out_valid), 0);
      release_and_check_quiet("accum abort");
      run_node("after accum abort", tbl[1].ins, tbl[1].exps, 100, 100, -1, cyc);

      // Abort a node mid-emission.
      for (int i = 0; i < DEG; i++) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.in_data   = 7'b0000001;
         bus.out_ready = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("emit abort reached emit", 32'(bus.out_valid), 1);
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("emit abort partial idx", 32'(bus.out_idx), 2);
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      #1;
      check("emit abort out_valid", 32'(bus.out_valid), 0);
      release_and_check_quiet("emit abort");
      run_node("after emit abort", tbl[3].ins, tbl[3].exps, 100, 100, -1, cyc);

      for (int n = 0; n < 1000; n++) begin
         for (int k = 0; k < DEG; k++) begin
            r[(DEG-1-k)*MW +: MW] = {1'($urandom_range(1)),
                                     ($urandom_range(1) == 1) ? 6'($urandom_range(3))
                                                              : 6'($urandom_range(63))};
         end
         vp = (n % 4 == 0) ? 100 : int'($urandom_range(30, 90));
         rp = (n % 4 == 0) ? 100 : int'($urandom_range(30, 90));
         run_node("random", r, model(r), vp, rp, -1, cyc);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("total outputs", total_out, nodes_run * DEG);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
